// File: rtl/maxpool2_stream_pkg.sv
// Shared CNN definitions: sample width, channel count, pixel type and Layer-2 frame size.
package cnn_pkg;
    localparam int DATA_BITS       = 32;
    localparam int CHANNELS        = 64;
    localparam int L2_IMAGE_WIDTH  = 13;
    localparam int L2_IMAGE_HEIGHT = 17;

    typedef logic signed [DATA_BITS-1:0] pixel_t [CHANNELS];

    function automatic logic signed [DATA_BITS-1:0] smax(
        input logic signed [DATA_BITS-1:0] a,
        input logic signed [DATA_BITS-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction
endpackage

// File: rtl/maxpool2_stream_if.sv
// Valid/data pixel beat stream without backpressure, one pixel_t per valid beat.
interface maxpool2_stream_if;
    import cnn_pkg::*;
    logic   valid;
    pixel_t data;

    modport master (output valid, output data);
    modport slave  (input  valid, input  data);
endinterface

// File: rtl/maxpool2_stream_vec_max2.sv
// Combinational per-channel signed maximum of two pixels.
module vec_max2
    import cnn_pkg::*;
(
    input  pixel_t a,
    input  pixel_t b,
    output pixel_t y
);
    // channel-wise max, ties return the shared value
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            y[k] = smax(a[k], b[k]);
        end
    end
endmodule

// File: rtl/maxpool2_stream.sv
// 2x2 stride-2 max pooling over a raster pixel stream using one half-width line buffer.
module maxpool2_stream
    import cnn_pkg::*;
#(
    parameter int IMAGE_WIDTH  = L2_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = L2_IMAGE_HEIGHT
) (
    input  logic                     clk,
    input  logic                     rst,
    maxpool2_stream_if.slave         in_if,
    maxpool2_stream_if.master        out_if,
    output logic                     frame_done
);
    localparam int OUT_W    = IMAGE_WIDTH / 2;
    localparam int OUT_H    = IMAGE_HEIGHT / 2;
    localparam int COL_BITS = $clog2(IMAGE_WIDTH);
    localparam int ROW_BITS = $clog2(IMAGE_HEIGHT);
    localparam int LB_BITS  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    pixel_t              hold_q, hold_d;
    pixel_t              data_out_q, data_out_d;
    logic                valid_out_q, valid_out_d;
    logic                frame_done_q, frame_done_d;

    pixel_t              linebuf_q [OUT_W];
    logic                lb_we_s;
    logic [LB_BITS-1:0]  lb_idx_s;
    pixel_t              lb_rd_s;
    pixel_t              max_hd_s;
    pixel_t              max_all_s;

    vec_max2 u_max_hd  (.a(hold_q),   .b(in_if.data), .y(max_hd_s));
    vec_max2 u_max_all (.a(max_hd_s), .b(lb_rd_s),    .y(max_all_s));

    // line-buffer index; the unused odd-width tail column maps to entry 0
    always_comb begin
        if ((col_q >> 1) < COL_BITS'(OUT_W)) begin
            lb_idx_s = LB_BITS'(col_q >> 1);
        end else begin
            lb_idx_s = '0;
        end
        lb_rd_s = linebuf_q[lb_idx_s];
    end

    // next-state: window accumulation, output capture and raster counters
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we_s      = 1'b0;
        if (in_if.valid) begin
            if (!col_q[0]) begin
                hold_d = in_if.data;
            end else if (!row_q[0]) begin
                // the trailing row of an odd-height frame never reaches the buffer
                lb_we_s = (row_q < ROW_BITS'(2 * OUT_H));
            end else begin
                data_out_d  = max_all_s;
                valid_out_d = 1'b1;
            end
            if (col_q == COL_BITS'(IMAGE_WIDTH - 1)) begin
                col_d = '0;
                if (row_q == ROW_BITS'(IMAGE_HEIGHT - 1)) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_BITS'(1);
                end
            end else begin
                col_d = col_q + COL_BITS'(1);
            end
        end else begin
            lb_we_s = 1'b0;
        end
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '{default: '0};
            data_out_q   <= '{default: '0};
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // line buffer storage; every even row rewrites it before it is read
    always_ff @(posedge clk) begin
        if (lb_we_s) begin
            linebuf_q[lb_idx_s] <= max_hd_s;
        end
    end

    assign out_if.valid = valid_out_q;
    assign out_if.data  = data_out_q;
    assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_maxpool2_stream.sv
// Self-checking bench for maxpool2_stream: table-driven frames against a window-level pooling model.
module tb_maxpool2_stream;
    import cnn_pkg::*;

    localparam int W  = 13;
    localparam int H  = 17;
    localparam int OW = 6;
    localparam int OH = 8;

    typedef struct {
        int mode;       // 0 ramp, 1 negatives, 2 discard edges, 3 random
        int max_gap;    // idle cycles 0..max_gap before each beat
        bit flush;      // settle and check the counts after this frame
        int exp_outs;   // pooled pixels expected since last flush
        int exp_fd;     // frame_done pulses expected since last flush
    } vec_t;

    typedef struct {
        int mode;
        int orow;
        int ocol;
        int ch;
        int exp;
    } spot_t;

    logic clk = 1'b0;
    logic rst;
    logic frame_done;

    maxpool2_stream_if in_if ();
    maxpool2_stream_if out_if ();

    maxpool2_stream dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (in_if),
        .out_if     (out_if),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    pixel_t frame  [H][W];
    pixel_t pooled [OH][OW];
    pixel_t exp_pix;
    bit     exp_vo = 1'b0;
    bit     exp_fd = 1'b0;
    int     exp_or = 0;
    int     exp_oc = 0;
    int     got [OH][OW][CHANNELS];
    int     n_seen_out = 0;
    int     n_seen_fd  = 0;
    bit     saw_1000   = 1'b0;
    vec_t   vecs  [7];
    spot_t  spots [7];

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic gen_frame(input int mode);
        logic signed [31:0] m;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    case (mode)
                        0: frame[r][c][k] = r * W + c + k;
                        1: frame[r][c][k] = (r == 1 && c == 1 && k == 3) ? -2 : -5;
                        2: frame[r][c][k] = (c == W - 1 || r == H - 1) ? 1000
                                          : int'($urandom_range(1000)) - 500;
                        default: frame[r][c][k] = $urandom;
                    endcase
                end
            end
        end
        for (int orr = 0; orr < OH; orr++) begin
            for (int oc = 0; oc < OW; oc++) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    m = frame[2*orr][2*oc][k];
                    if (frame[2*orr][2*oc+1][k]   > m) m = frame[2*orr][2*oc+1][k];
                    if (frame[2*orr+1][2*oc][k]   > m) m = frame[2*orr+1][2*oc][k];
                    if (frame[2*orr+1][2*oc+1][k] > m) m = frame[2*orr+1][2*oc+1][k];
                    pooled[orr][oc][k] = m;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int bad;
        bad = -1;
        chk(out_if.valid === exp_vo, "valid_out", out_if.valid, exp_vo);
        chk(frame_done === exp_fd, "frame_done", frame_done, exp_fd);
        if (out_if.valid === 1'b1) begin
            n_seen_out++;
            for (int k = 0; k < CHANNELS; k++) begin
                if (out_if.data[k] == 32'sd1000) saw_1000 = 1'b1;
            end
        end
        if (frame_done === 1'b1) n_seen_fd++;
        if (exp_vo) begin
            for (int k = 0; k < CHANNELS; k++) begin
                got[exp_or][exp_oc][k] = out_if.data[k];
                if (out_if.data[k] !== exp_pix[k] && bad < 0) bad = k;
            end
            if (bad < 0) chk(1'b1, "data_out", 0, 0);
            else chk(1'b0, $sformatf("data_out(%0d,%0d) ch%0d", exp_or, exp_oc, bad),
                     out_if.data[bad], exp_pix[bad]);
        end
    endtask

    // one cycle: check last cycle's results, then drive beat (r,c) or an idle cycle
    task automatic step(input bit v, input int r, input int c);
        @(negedge clk);
        check_outputs();
        exp_vo = 1'b0;
        exp_fd = 1'b0;
        if (v) begin
            if (r % 2 == 1 && c % 2 == 1 && r < 2 * OH && c < 2 * OW) begin
                exp_vo  = 1'b1;
                exp_or  = r / 2;
                exp_oc  = c / 2;
                exp_pix = pooled[r/2][c/2];
            end
            if (r == H - 1 && c == W - 1) exp_fd = 1'b1;
            in_if.valid = 1'b1;
            in_if.data  = frame[r][c];
        end else begin
            in_if.valid = 1'b0;
        end
    endtask

    task automatic run_frame(input int mode, input int max_gap, input int n_beats);
        int g;
        gen_frame(mode);
        for (int b = 0; b < n_beats; b++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
            repeat (g) step(1'b0, 0, 0);
            step(1'b1, b / W, b % W);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        int nz;
        nz = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (out_if.data[k] !== 32'sd0) nz++;
        end
        chk(out_if.valid === 1'b0, {tag, " valid_out"}, out_if.valid, 0);
        chk(frame_done === 1'b0, {tag, " frame_done"}, frame_done, 0);
        chk(nz == 0, {tag, " data_out nonzero channels"}, nz, 0);
    endtask

    initial begin
        vecs[0] = '{mode: 0, max_gap: 0, flush: 1'b1, exp_outs: 48, exp_fd: 1};
        vecs[1] = '{mode: 1, max_gap: 0, flush: 1'b1, exp_outs: 48, exp_fd: 1};
        vecs[2] = '{mode: 0, max_gap: 3, flush: 1'b1, exp_outs: 48, exp_fd: 1};
        vecs[3] = '{mode: 2, max_gap: 2, flush: 1'b1, exp_outs: 48, exp_fd: 1};
        vecs[4] = '{mode: 3, max_gap: 1, flush: 1'b1, exp_outs: 48, exp_fd: 1};
        vecs[5] = '{mode: 3, max_gap: 0, flush: 1'b0, exp_outs: 0,  exp_fd: 0};
        vecs[6] = '{mode: 3, max_gap: 0, flush: 1'b1, exp_outs: 96, exp_fd: 2};

        spots[0] = '{mode: 0, orow: 0, ocol: 0, ch: 0, exp: 14};
        spots[1] = '{mode: 0, orow: 0, ocol: 0, ch: 5, exp: 19};
        spots[2] = '{mode: 0, orow: 7, ocol: 5, ch: 0, exp: 206};
        spots[3] = '{mode: 0, orow: 3, ocol: 2, ch: 1, exp: 97};
        spots[4] = '{mode: 1, orow: 0, ocol: 0, ch: 3, exp: -2};
        spots[5] = '{mode: 1, orow: 0, ocol: 0, ch: 0, exp: -5};
        spots[6] = '{mode: 1, orow: 4, ocol: 4, ch: 3, exp: -5};

        rst         = 1'b1;
        in_if.valid = 1'b0;
        in_if.data  = '{default: '0};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < 7; i++) begin
            saw_1000 = 1'b0;
            run_frame(vecs[i].mode, vecs[i].max_gap, H * W);
            if (vecs[i].flush) begin
                step(1'b0, 0, 0);
                chk(n_seen_out == vecs[i].exp_outs, $sformatf("vec%0d output count", i),
                    n_seen_out, vecs[i].exp_outs);
                chk(n_seen_fd == vecs[i].exp_fd, $sformatf("vec%0d frame_done count", i),
                    n_seen_fd, vecs[i].exp_fd);
                if (vecs[i].mode == 2) chk(!saw_1000, "edge value 1000 leaked", saw_1000, 0);
                for (int s = 0; s < 7; s++) begin
                    if (spots[s].mode == vecs[i].mode) begin
                        chk(got[spots[s].orow][spots[s].ocol][spots[s].ch] == spots[s].exp,
                            $sformatf("spot vec%0d out(%0d,%0d) ch%0d", i, spots[s].orow,
                                      spots[s].ocol, spots[s].ch),
                            got[spots[s].orow][spots[s].ocol][spots[s].ch], spots[s].exp);
                    end
                end
                n_seen_out = 0;
                n_seen_fd  = 0;
            end
        end

        // reset after 100 beats discards the partial frame
        run_frame(3, 0, 100);
        step(1'b0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("mid-frame reset");
        n_seen_out = 0;
        n_seen_fd  = 0;
        run_frame(3, 1, H * W);
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
        chk(n_seen_out == 48, "post-reset output count", n_seen_out, 48);
        chk(n_seen_fd == 1, "post-reset frame_done count", n_seen_fd, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
